// File: rtl/soc_spi_pkg.sv
// Shared definitions for the SPI flash responder: opcodes, FSM states, data sources.
package soc_spi_pkg;

    localparam logic [7:0] OP_READ = 8'h03;
    localparam logic [7:0] OP_RDID = 8'h9F;
    localparam logic [7:0] OP_RDSR = 8'h05;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } state_e;

    typedef enum logic [1:0] {
        SRC_MEM,
        SRC_ID,
        SRC_SR
    } src_e;

    // Select one byte of the 24-bit JEDEC ID, MSB byte at index 0.
    function automatic logic [7:0] id_byte(input logic [23:0] id, input logic [1:0] idx);
        case (idx)
            2'd0:    return id[23:16];
            2'd1:    return id[15:8];
            default: return id[7:0];
        endcase
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage synchronizer for an asynchronous SPI pin with rise/fall pulses on the synced level.
module spi_sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic level_o,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_c  = sync_q[STAGES-1] & ~prev_q;
    assign fall_c  = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash responder: serves READ/RDID/RDSR from a byte-wide read port,
// with all SPI pins oversampled in the clk domain.
module spi_flash_responder
    import soc_spi_pkg::*;
#(
    parameter int unsigned MEM_AW      = 24,
    parameter logic [23:0] JEDEC_ID    = 24'h20BA18,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_clk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              mem_rd_en,
    output logic [MEM_AW-1:0] mem_rd_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              busy,
    output logic              cmd_err
);

    logic sck_lvl, sck_rise, sck_fall;
    logic cs_lvl, cs_rise, cs_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst(rst), .d_i(spi_clk),
        .level_o(sck_lvl), .rise_c(sck_rise), .fall_c(sck_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(spi_cs_n),
        .level_o(cs_lvl), .rise_c(cs_rise), .fall_c(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(spi_mosi),
        .level_o(mosi_lvl), .rise_c(mosi_rise), .fall_c(mosi_fall)
    );

    state_e            state_q, state_d;
    src_e              src_q, src_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [1:0]        id_idx_q, id_idx_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [23:0]       addr_q, addr_d;
    logic [7:0]        buf_q, buf_d;
    logic [7:0]        tx_q, tx_d;
    logic              rd_pend_q, rd_pend_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              mem_rd_en_q, mem_rd_en_d;
    logic [MEM_AW-1:0] mem_rd_addr_q, mem_rd_addr_d;
    logic              busy_q, busy_d;
    logic              cmd_err_q, cmd_err_d;

    logic [7:0]        cmd_in;
    logic [23:0]       addr_in;
    logic              unused_bits;

    assign cmd_in      = {cmd_q[6:0], mosi_lvl};
    assign addr_in     = {addr_q[22:0], mosi_lvl};
    assign unused_bits = ^{sck_lvl, cs_rise, mosi_rise, mosi_fall, cmd_q[7], addr_q[23]};

    always_comb begin
        state_d       = state_q;
        src_d         = src_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        id_idx_d      = id_idx_q;
        cmd_d         = cmd_q;
        addr_d        = addr_q;
        buf_d         = buf_q;
        tx_d          = tx_q;
        rd_pend_d     = mem_rd_en_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        mem_rd_en_d   = 1'b0;
        mem_rd_addr_d = mem_rd_addr_q;
        cmd_err_d     = 1'b0;

        // Read data arrives one clk after the strobe and lands in the prefetch buffer.
        if (rd_pend_q) begin
            buf_d = mem_rd_data;
        end

        if (cs_lvl) begin
            state_d    = ST_IDLE;
            bit_cnt_d  = 3'd0;
            byte_cnt_d = 2'd0;
            tx_d       = 8'h00;
            miso_d     = 1'b0;
            miso_oe_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_d  = 3'd0;
                    byte_cnt_d = 2'd0;
                    if (cs_fall) begin
                        state_d = ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (sck_rise) begin
                        cmd_d     = cmd_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            case (cmd_in)
                                OP_READ: begin
                                    state_d    = ST_ADDR;
                                    byte_cnt_d = 2'd0;
                                end
                                OP_RDID: begin
                                    state_d   = ST_DATA;
                                    src_d     = SRC_ID;
                                    buf_d     = id_byte(JEDEC_ID, 2'd0);
                                    id_idx_d  = 2'd1;
                                    miso_oe_d = 1'b1;
                                end
                                OP_RDSR: begin
                                    state_d   = ST_DATA;
                                    src_d     = SRC_SR;
                                    buf_d     = 8'h00;
                                    miso_oe_d = 1'b1;
                                end
                                default: begin
                                    state_d   = ST_IGNORE;
                                    cmd_err_d = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ST_ADDR: begin
                    if (sck_rise) begin
                        addr_d    = addr_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            if (byte_cnt_q == 2'd2) begin
                                state_d       = ST_DATA;
                                src_d         = SRC_MEM;
                                mem_rd_en_d   = 1'b1;
                                mem_rd_addr_d = addr_in[MEM_AW-1:0];
                                miso_oe_d     = 1'b1;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    miso_oe_d = 1'b1;
                    if (sck_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    if (sck_fall) begin
                        // Byte boundary: move the prefetch buffer into the shifter and refill it.
                        if (bit_cnt_q == 3'd0) begin
                            miso_d = buf_q[7];
                            tx_d   = {buf_q[6:0], 1'b0};
                            case (src_q)
                                SRC_MEM: begin
                                    mem_rd_en_d   = 1'b1;
                                    mem_rd_addr_d = mem_rd_addr_q + MEM_AW'(1);
                                end
                                SRC_ID: begin
                                    buf_d    = id_byte(JEDEC_ID, id_idx_q);
                                    id_idx_d = (id_idx_q == 2'd2) ? 2'd0 : id_idx_q + 2'd1;
                                end
                                default: begin
                                    buf_d = 8'h00;
                                end
                            endcase
                        end else begin
                            miso_d = tx_q[7];
                            tx_d   = {tx_q[6:0], 1'b0};
                        end
                    end
                end
                ST_IGNORE: begin
                    miso_oe_d = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            src_q         <= SRC_MEM;
            bit_cnt_q     <= 3'd0;
            byte_cnt_q    <= 2'd0;
            id_idx_q      <= 2'd0;
            cmd_q         <= 8'h00;
            addr_q        <= 24'h000000;
            buf_q         <= 8'h00;
            tx_q          <= 8'h00;
            rd_pend_q     <= 1'b0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            busy_q        <= 1'b0;
            cmd_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            src_q         <= src_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            id_idx_q      <= id_idx_d;
            cmd_q         <= cmd_d;
            addr_q        <= addr_d;
            buf_q         <= buf_d;
            tx_q          <= tx_d;
            rd_pend_q     <= rd_pend_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            busy_q        <= busy_d;
            cmd_err_q     <= cmd_err_d;
        end
    end

    assign spi_miso    = miso_q;
    assign spi_miso_oe = miso_oe_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign busy        = busy_q;
    assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench: an SPI mode-0 master and a byte store drive the responder; a flash-level model predicts results.
module tb_spi_flash_responder;

    localparam int unsigned MEM_AW      = 24;
    localparam logic [23:0] JEDEC       = 24'h20BA18;
    localparam int unsigned SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              spi_clk = 1'b0;
    logic              spi_cs_n = 1'b1;
    logic              spi_mosi = 1'b0;
    logic              spi_miso;
    logic              spi_miso_oe;
    logic              mem_rd_en;
    logic [MEM_AW-1:0] mem_rd_addr;
    logic [7:0]        mem_rd_data = 8'h00;
    logic              busy;
    logic              cmd_err;

    int errs = 0;
    int checks = 0;
    int err_pulses = 0;
    logic [23:0] rd_log[$];
    logic oe_any, oe_all;

    spi_flash_responder #(
        .MEM_AW(MEM_AW), .JEDEC_ID(JEDEC), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk), .rst(rst),
        .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    // Backing store: one-clk read latency; every strobe is logged.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem_rd_addr[7:0] ^ 8'h5A;
            rd_log.push_back(mem_rd_addr);
        end
        if (cmd_err) err_pulses++;
    end

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] id_exp(input int i);
        logic [23:0] id = JEDEC;
        return 8'(id >> (8 * (2 - (i % 3))));
    endfunction

    // SPI master primitives; every SCK edge lands on a clk falling edge.
    task automatic bit_xfer(input logic b, output logic r);
        spi_mosi = b;
        #50;
        r = spi_miso;
        oe_any = oe_any | spi_miso_oe;
        oe_all = oe_all & spi_miso_oe;
        spi_clk = 1'b1;
        #50;
        spi_clk = 1'b0;
    endtask

    task automatic byte_xfer(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_begin();
        @(negedge clk);
        spi_cs_n = 1'b0;
    endtask

    task automatic cs_end();
        #50;
        spi_cs_n = 1'b1;
        #200;
    endtask

    task automatic do_read(input logic [23:0] a, input int n, input string nm);
        logic [7:0] rx;
        logic [23:0] ea;
        rd_log.delete();
        cs_begin();
        byte_xfer(8'h03, rx);
        byte_xfer(a[23:16], rx);
        byte_xfer(a[15:8], rx);
        byte_xfer(a[7:0], rx);
        oe_all = 1'b1;
        for (int i = 0; i < n; i++) begin
            byte_xfer(8'h00, rx);
            ea = a + 24'(i);
            checks++;
            if (rx !== mem_byte(ea)) begin
                errs++;
                $display("FAIL %s byte%0d: got %02h want %02h", nm, i, rx, mem_byte(ea));
            end
        end
        cs_end();
        checks++;
        if (oe_all !== 1'b1) begin
            errs++;
            $display("FAIL %s miso_oe during data: got %b want 1", nm, oe_all);
        end
        checks++;
        if (rd_log.size() < n + 1 || rd_log.size() > n + 2) begin
            errs++;
            $display("FAIL %s fetch count: got %0d want %0d..%0d", nm, rd_log.size(), n + 1, n + 2);
        end else begin
            for (int i = 0; i < rd_log.size(); i++) begin
                ea = a + 24'(i);
                checks++;
                if (rd_log[i] !== ea) begin
                    errs++;
                    $display("FAIL %s fetch%0d addr: got %06h want %06h", nm, i, rd_log[i], ea);
                end
            end
        end
    endtask

    task automatic do_reg(input logic [7:0] op, input int n, input string nm);
        logic [7:0] rx, ex;
        rd_log.delete();
        cs_begin();
        byte_xfer(op, rx);
        for (int i = 0; i < n; i++) begin
            byte_xfer(8'h00, rx);
            ex = (op == 8'h9F) ? id_exp(i) : 8'h00;
            checks++;
            if (rx !== ex) begin
                errs++;
                $display("FAIL %s byte%0d: got %02h want %02h", nm, i, rx, ex);
            end
        end
        cs_end();
        checks++;
        if (rd_log.size() != 0) begin
            errs++;
            $display("FAIL %s mem reads: got %0d want 0", nm, rd_log.size());
        end
    endtask

    task automatic do_bad(input logic [7:0] op, input string nm);
        logic [7:0] rx;
        int p0;
        p0 = err_pulses;
        cs_begin();
        byte_xfer(op, rx);
        oe_any = 1'b0;
        byte_xfer(8'hFF, rx);
        byte_xfer(8'h00, rx);
        checks++;
        if (oe_any !== 1'b0 || rx !== 8'h00) begin
            errs++;
            $display("FAIL %s after opcode: oe=%b miso byte=%02h want 0/00", nm, oe_any, rx);
        end
        checks++;
        if (err_pulses - p0 != 1) begin
            errs++;
            $display("FAIL %s cmd_err pulses: got %0d want 1", nm, err_pulses - p0);
        end
        cs_end();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({spi_miso, spi_miso_oe, mem_rd_en, busy, cmd_err} !== 5'b0 || mem_rd_addr !== '0) begin
            errs++;
            $display("FAIL reset outputs: got %b/%06h want 00000/000000",
                     {spi_miso, spi_miso_oe, mem_rd_en, busy, cmd_err}, mem_rd_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        #200;
    endtask

    task automatic test_read();
        do_read(24'h000010, 4, "read_0x10");
    endtask

    task automatic test_id_sr();
        do_reg(8'h9F, 4, "rdid");
        do_reg(8'h05, 2, "rdsr");
    endtask

    task automatic test_wrap();
        do_read(24'hFFFFFF, 2, "read_wrap");
    endtask

    task automatic test_bad_opcode();
        logic [7:0] rx;
        cs_begin();
        byte_xfer(8'hAB, rx);
        oe_any = 1'b0;
        byte_xfer(8'h00, rx);
        checks++;
        if (oe_any !== 1'b0) begin
            errs++;
            $display("FAIL bad_op oe: got %b want 0", oe_any);
        end
        #50;
        spi_cs_n = 1'b1;
        repeat (SYNC_STAGES) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errs++;
            $display("FAIL bad_op busy early: got %b want 1", busy);
        end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL bad_op busy release: got %b want 0", busy);
        end
        #200;
        do_bad(8'hAB, "bad_op_0xAB");
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        logic r;
        cs_begin();
        byte_xfer(8'h03, rx);
        for (int i = 0; i < 12; i++) bit_xfer(1'b1, r);
        cs_end();
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL abort busy: got %b want 0", busy);
        end
        do_read(24'h000001, 1, "read_after_abort");
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        logic r;
        cs_begin();
        byte_xfer(8'h03, rx);
        byte_xfer(8'h00, rx);
        byte_xfer(8'h00, rx);
        byte_xfer(8'h20, rx);
        byte_xfer(8'h00, rx);
        for (int i = 0; i < 4; i++) bit_xfer(1'b0, r);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({spi_miso, spi_miso_oe, mem_rd_en, busy, cmd_err} !== 5'b0 || mem_rd_addr !== '0) begin
            errs++;
            $display("FAIL mid_reset outputs: got %b/%06h want 00000/000000",
                     {spi_miso, spi_miso_oe, mem_rd_en, busy, cmd_err}, mem_rd_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) bit_xfer(1'b0, r);
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset busy before reselect: got %b want 0", busy);
        end
        cs_end();
        do_reg(8'h9F, 1, "rdid_after_reset");
    endtask

    task automatic test_random();
        logic [7:0] op;
        for (int t = 0; t < 12; t++) begin
            case ($urandom_range(0, 3))
                0: do_read(24'($urandom()), int'($urandom_range(1, 4)), "rand_read");
                1: do_reg(8'h9F, int'($urandom_range(1, 5)), "rand_rdid");
                2: do_reg(8'h05, int'($urandom_range(1, 3)), "rand_rdsr");
                default: begin
                    op = 8'($urandom());
                    while (op == 8'h03 || op == 8'h9F || op == 8'h05) op = 8'($urandom());
                    do_bad(op, "rand_bad");
                end
            endcase
        end
    endtask

    task automatic test_back_to_back();
        do_read(24'h00ABCD, 2, "b2b_first");
        do_read(24'h00ABCF, 3, "b2b_second");
    endtask

    initial begin
        oe_any = 1'b0;
        oe_all = 1'b1;
        test_reset();
        test_read();
        test_id_sr();
        test_wrap();
        test_bad_opcode();
        test_abort();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
